pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register for the x86 pipeline.
- Generalises the plain enable-gated register into a two-entry skid buffer:
  - valid/ready handshake on both sides
  - synchronous flush
  - programmable reset value
  - true/complement data outputs
- Sits between pipeline stages (e.g. fetch->decode, decode->agen) so that a downstream stall does not need a combinational ready path back to the upstream stage.

Parameters:
- WIDTH, 16, payload width in bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into both data entries on reset.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; drops all held entries.
- in_valid  input  1  upstream presents data.
- in_ready  output  1  stage can accept data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds valid data.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head entry payload.
- out_data_bar  output  WIDTH  bitwise complement of out_data.
- skid_full  output  1  skid entry occupied (debug/perf).
- stall_cnt  output  STALL_CNT_W  only present with PIPE_SKID_STALL_CNT_EN.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Nothing changes between edges except combinational outputs.
- Storage:
  - main entry: main_data, main_valid
  - skid entry: skid_data, skid_valid
- State machine, encoded by (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1). The combination (0,1) is illegal and must never occur.
- Outputs, all decoded from registered state only:
  - out_valid = main_valid
  - out_data = main_data
  - out_data_bar = ~main_data
  - in_ready = ~skid_valid
  - skid_full = skid_valid
- Handshakes:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Transitions (when no reset and no flush):
  - EMPTY: in_fire -> ONE, main_data<=in_data. Otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> ONE, main_data<=in_data.
  - ONE, out_fire only -> EMPTY.
  - ONE, in_fire only -> FULL, skid_data<=in_data.
  - ONE, neither -> hold.
  - FULL: in_ready=0. out_fire -> ONE, main_data<=skid_data. Otherwise hold.
- Latency: data accepted at edge N appears on out_data after edge N (1 cycle) when the stage is EMPTY, or when it is ONE and the head fires the same cycle.
- Ordering: strict FIFO order; no entry is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Backpressure: in_ready deasserts only after an entry has been accepted while out_ready=0. Upstream therefore sees ready fall one cycle late, which the skid entry absorbs.
- out_ready while EMPTY: ignored.
- in_valid while FULL: ignored. Upstream must hold its data per the handshake rule.
- Flush:
  - At the edge: main_valid<=0, skid_valid<=0.
  - Data registers are left unchanged.
  - in_data presented in the flush cycle is discarded even if in_valid=1.
  - in_ready is still evaluated from the pre-flush state.
- Reset:
  - At the edge: main_valid<=0, skid_valid<=0, main_data<=RESET_VAL, skid_data<=RESET_VAL.
  - After reset: out_valid=0, in_ready=1, out_data=RESET_VAL, out_data_bar=~RESET_VAL, skid_full=0.
  - Priority: reset > flush > handshake.
  - Reset asserted mid-transfer (any state) discards all contents at that edge.
- Clocking: no gated clock; enables are implemented as data-path muxes into the flops.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - Port stall_cnt exists.
  - Increments by 1 on every edge where out_valid=1 and out_ready=0.
  - Saturates at all-ones and does not wrap.
  - Cleared to 0 by reset; flush does not clear it.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, WIDTH=16, RESET_VAL=16'h00FF -> after the reset edge: out_valid=0, in_ready=1, out_data=16'h00FF, out_data_bar=16'hFF00, skid_full=0.
- Streaming: out_ready=1, push 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> each appears on out_data one cycle later, back-to-back; in_ready stays 1.
- Stall fill:
  - Push 16'hAAAA, then drop out_ready to 0 and push 16'hBBBB -> FULL, in_ready=0, skid_full=1, out_data=16'hAAAA held.
  - Raise out_ready -> next cycle out_data=16'hBBBB, in_ready=1.
- Flush in FULL with in_valid=1, in_data=16'hCCCC -> next cycle out_valid=0, in_ready=1; 16'hCCCC never appears on the output.
- Reset mid-operation: reset asserted in ONE together with in_valid=1 -> next cycle EMPTY, out_data=RESET_VAL.
- With PIPE_SKID_STALL_CNT_EN, STALL_CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=4'hF (saturated); flush leaves it at 4'hF; reset returns it to 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline stage register with flush, reset value and true/complement outputs.
// Optional saturating stall counter is enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_reg #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
    parameter int unsigned      STALL_CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_data_bar,
    output logic             skid_full
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // State encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] main_data_r;
    logic [WIDTH-1:0] main_data_s;
    logic [WIDTH-1:0] skid_data_r;
    logic [WIDTH-1:0] skid_data_s;
    logic             main_valid_s;
    logic             skid_valid_s;
    logic             in_fire_s;
    logic             out_fire_s;

    if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
        $error("pipe_skid_reg: STALL_CNT_W must be at least 1");
    end

    assign main_valid_s = state_r[1];
    assign skid_valid_s = state_r[0];
    assign in_fire_s    = in_valid & ~skid_valid_s;
    assign out_fire_s   = main_valid_s & out_ready;

    assign out_valid    = main_valid_s;
    assign out_data     = main_data_r;
    assign out_data_bar = ~main_data_r;
    assign in_ready     = ~skid_valid_s;
    assign skid_full    = skid_valid_s;

    // Next-state and data-path enable muxes for the handshake transitions.
    always_comb begin
        state_s     = state_r;
        main_data_s = main_data_r;
        skid_data_s = skid_data_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_s     = ST_ONE;
                    main_data_s = in_data;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    state_s     = ST_ONE;
                    main_data_s = in_data;
                end else if (out_fire_s) begin
                    state_s = ST_EMPTY;
                end else if (in_fire_s) begin
                    state_s     = ST_FULL;
                    skid_data_s = in_data;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    state_s     = ST_ONE;
                    main_data_s = skid_data_r;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                // Unreachable encoding: fall back to empty rather than emit a phantom entry.
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State and entry registers; flush drops validity but leaves the data flops alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            main_data_r <= RESET_VAL;
            skid_data_r <= RESET_VAL;
        end else if (flush) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r     <= state_s;
            main_data_r <= main_data_s;
            skid_data_r <= skid_data_s;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1'b1);

    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where the head is held by downstream backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (main_valid_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed test-plan sequences followed by random traffic.
module tb_pipe_skid_reg;

    localparam logic [15:0] RV = 16'h00FF;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_data_bar;
    logic        skid_full;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    bit          known = 1'b0;
    bit          idle_rst = 1'b0;
    int          stall_exp = 0;

    pipe_skid_reg #(
        .WIDTH      (16),
        .RESET_VAL  (RV),
        .STALL_CNT_W(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_data_bar(out_data_bar),
        .skid_full   (skid_full)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then return just after the rising edge.
    task automatic cyc(input logic r, input logic f, input logic iv, input logic [15:0] d, input logic ordy);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Monitor and reference model: a FIFO of at most two entries, sampled mid-cycle.
    initial begin
        logic [15:0] exp_bar;
        logic [15:0] rv_bar;
        bit          in_rdy_m;
        bit          head_m;
        rv_bar = ~RV;
        forever begin
            @(negedge clk);
            if (known) begin
                chk("out_valid", {31'd0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
                chk("in_ready", {31'd0, in_ready}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
                chk("skid_full", {31'd0, skid_full}, (exp_q.size() == 2) ? 32'd1 : 32'd0);
                if (exp_q.size() > 0) begin
                    exp_bar = ~exp_q[0];
                    chk("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
                    chk("out_data_bar", {16'd0, out_data_bar}, {16'd0, exp_bar});
                end else if (idle_rst) begin
                    chk("reset_data", {16'd0, out_data}, {16'd0, RV});
                    chk("reset_data_bar", {16'd0, out_data_bar}, {16'd0, rv_bar});
                end
`ifdef PIPE_SKID_STALL_CNT_EN
                chk("stall_cnt", {28'd0, stall_cnt}, stall_exp);
`endif
            end
            in_rdy_m = (exp_q.size() < 2);
            head_m   = (exp_q.size() > 0);
            if (reset) begin
                known     = 1'b1;
                idle_rst  = 1'b1;
                stall_exp = 0;
                exp_q.delete();
            end else if (known) begin
                if (head_m && !out_ready && stall_exp < 15) stall_exp++;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (head_m && out_ready) void'(exp_q.pop_front());
                    if (in_valid && in_rdy_m) begin
                        exp_q.push_back(in_data);
                        idle_rst = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Streaming at full rate.
        cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'h2222, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'h3333, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Stall fill into the skid entry, then drain.
        cyc(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 16'hBBBB, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'hDDDD, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Flush while full with a competing push.
        cyc(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 16'hCCCC, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Reset in ONE with a competing push.
        cyc(1'b0, 1'b0, 1'b1, 16'h4321, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'h9999, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
        cyc(1'b0, 1'b0, 1'b1, 16'h7777, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("stall_sat", {28'd0, stall_cnt}, 32'hF);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("stall_after_flush", {28'd0, stall_cnt}, 32'hF);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("stall_after_reset", {28'd0, stall_cnt}, 32'h0);
`endif
        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            d = 16'($urandom);
            cyc(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(31) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(9) < 6) ? 1'b1 : 1'b0,
                d,
                ($urandom_range(9) < 6) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
